// File: rtl/riscv_decode_stage.sv
// -----------------------------------------------------------------------------
// riscv_decode_stage
//   Registered RV32I decode stage between fetch and execute. Each accepted
//   instruction is turned into one decoded bundle (ALU op, operand selects,
//   sign-extended immediate, register indices, memory and control-transfer
//   flags) that appears on the dec_* outputs one cycle after acceptance.
//
//   Handshake (both sides): a transfer happens on a rising clk edge where
//   valid && ready. A producer holds valid and its payload stable until the
//   transfer; ready may be low at any time. instr_* is the input side and
//   dec_* the output side. While dec_valid && !dec_ready the bundle is held
//   bit-stable.
//
//   Optional feature (macro DECODE_SKID_EN):
//     defined   - one output register plus one skid register; instr_ready is
//                 a registered "skid empty" flag, gated only by flush.
//     undefined - single output register; instr_ready = !dec_valid || dec_ready.
//
// Parameters
//   ALUOP_W    width of alu_op (ALU_* codes of the ALU)
//   STRICT_F7  1: non-canonical funct7 on OP / shift-imm is illegal;
//              0: only funct7[5] is looked at
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous flush; discards everything in the stage
//   instr_valid/ready   input handshake; instr, instr_pc payload
//   dec_valid/ready     output handshake
//   dec_pc              pc of the decoded instruction
//   alu_op              ALU operation code
//   src_a_sel           0=rs1, 1=pc, 2=zero
//   src_b_sel           0=rs2, 1=imm, 2=const 4
//   imm                 sign-extended immediate (0 when the format has none)
//   rs1, rs2, rd        register indices (0 when unused)
//   reg_we              instruction writes rd
//   mem_req, mem_we     load/store request, store
//   mem_size            funct3 of the load/store
//   branch, jal, jalr   control-transfer type
//   illegal             undecodable instruction (bundle otherwise inert)
// -----------------------------------------------------------------------------
module riscv_decode_stage #(
  parameter int ALUOP_W   = 5,
  parameter bit STRICT_F7 = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic [31:0]        instr_pc,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [31:0]        dec_pc,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         src_a_sel,
  output logic [1:0]         src_b_sel,
  output logic [31:0]        imm,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic               reg_we,
  output logic               mem_req,
  output logic               mem_we,
  output logic [2:0]         mem_size,
  output logic               branch,
  output logic               jal,
  output logic               jalr,
  output logic               illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IMM  = 2'd1;
  localparam logic [1:0] SRCB_FOUR = 2'd2;

  localparam logic [4:0] ALU_ADD = 5'b00000;

  typedef struct packed {
    logic [31:0]        pc;
    logic [ALUOP_W-1:0] alu_op;
    logic [1:0]         src_a_sel;
    logic [1:0]         src_b_sel;
    logic [31:0]        imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               reg_we;
    logic               mem_req;
    logic               mem_we;
    logic [2:0]         mem_size;
    logic               branch;
    logic               jal;
    logic               jalr;
    logic               illegal;
  } bundle_t;

  // ---------------------------------------------------------------------------
  // Instruction fields and immediates for every format
  // ---------------------------------------------------------------------------
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [4:0]  rd_f;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign rd_f   = instr[11:7];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // funct7 legality. With STRICT_F7=0 every funct7 is accepted and only
  // funct7[5] (the SUB/SRA selector) influences the decode.
  logic f7_zero;
  logic f7_alt;
  logic shl_ok;
  logic shr_ok;
  logic op_f7_ok;

  assign f7_zero  = (f7 == 7'h00);
  assign f7_alt   = (f7 == 7'h20);
  assign shl_ok   = !STRICT_F7 || f7_zero;
  assign shr_ok   = !STRICT_F7 || f7_zero || f7_alt;
  // Only ADD/SUB (f3=000) and SRL/SRA (f3=101) have an alternate encoding.
  assign op_f7_ok = !STRICT_F7 || f7_zero ||
                    (f7_alt && ((f3 == 3'b000) || (f3 == 3'b101)));

  // ---------------------------------------------------------------------------
  // Combinational decode of the instruction on the input port
  // ---------------------------------------------------------------------------
  bundle_t dec;
  logic    bad;

  always_comb begin
    bad    = 1'b0;
    dec    = '0;
    dec.pc = instr_pc;
    case (opcode)
      OPC_LUI: begin
        dec.src_a_sel = SRCA_ZERO;
        dec.src_b_sel = SRCB_IMM;
        dec.imm       = imm_u;
        dec.rd        = rd_f;
        dec.reg_we    = 1'b1;
      end
      OPC_AUIPC: begin
        dec.src_a_sel = SRCA_PC;
        dec.src_b_sel = SRCB_IMM;
        dec.imm       = imm_u;
        dec.rd        = rd_f;
        dec.reg_we    = 1'b1;
      end
      OPC_JAL: begin
        // ALU computes the link address pc+4; the target uses imm.
        dec.src_a_sel = SRCA_PC;
        dec.src_b_sel = SRCB_FOUR;
        dec.imm       = imm_j;
        dec.rd        = rd_f;
        dec.reg_we    = 1'b1;
        dec.jal       = 1'b1;
      end
      OPC_JALR: begin
        dec.src_a_sel = SRCA_PC;
        dec.src_b_sel = SRCB_FOUR;
        dec.imm       = imm_i;
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.reg_we    = 1'b1;
        dec.jalr      = 1'b1;
        bad           = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.alu_op    = ALUOP_W'({2'b11, f3});
        dec.src_a_sel = SRCA_RS1;
        dec.src_b_sel = SRCB_RS2;
        dec.imm       = imm_b;
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.branch    = 1'b1;
        bad           = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        dec.src_a_sel = SRCA_RS1;
        dec.src_b_sel = SRCB_IMM;
        dec.imm       = imm_i;
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.reg_we    = 1'b1;
        dec.mem_req   = 1'b1;
        dec.mem_size  = f3;
        bad           = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec.src_a_sel = SRCA_RS1;
        dec.src_b_sel = SRCB_IMM;
        dec.imm       = imm_s;
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.mem_req   = 1'b1;
        dec.mem_we    = 1'b1;
        dec.mem_size  = f3;
        bad           = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        // Only SRAI uses funct7[5]; for other I-type ops those bits are immediate.
        dec.alu_op    = ALUOP_W'({1'b0, f7[5] & (f3 == 3'b101), f3});
        dec.src_a_sel = SRCA_RS1;
        dec.src_b_sel = SRCB_IMM;
        dec.imm       = imm_i;
        dec.rs1       = rs1_f;
        dec.rd        = rd_f;
        dec.reg_we    = 1'b1;
        if (f3 == 3'b001) begin
          bad = !shl_ok;
        end else if (f3 == 3'b101) begin
          bad = !shr_ok;
        end
      end
      OPC_OP: begin
        dec.alu_op    = ALUOP_W'({1'b0, f7[5], f3});
        dec.src_a_sel = SRCA_RS1;
        dec.src_b_sel = SRCB_RS2;
        dec.rs1       = rs1_f;
        dec.rs2       = rs2_f;
        dec.rd        = rd_f;
        dec.reg_we    = 1'b1;
        bad           = !op_f7_ok;
      end
      OPC_MISC: begin
        // FENCE: ordering is trivially satisfied by this in-order pipe -> NOP.
      end
      default: begin
        // SYSTEM and every unknown opcode.
        bad = 1'b1;
      end
    endcase

    if (bad || (instr[1:0] != 2'b11)) begin
      dec         = '0;
      dec.pc      = instr_pc;
      dec.alu_op  = ALUOP_W'(ALU_ADD);
      dec.illegal = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline register(s)
  // ---------------------------------------------------------------------------
  bundle_t out_q;
  logic    dec_valid_q;
  logic    accept;

`ifdef DECODE_SKID_EN
  bundle_t skid_q;
  logic    skid_valid_q;
  logic    ready_q;
  logic    out_free;

  // ready_q always equals !skid_valid_q; kept as its own flop so instr_ready
  // has no combinational dependence on dec_ready.
  assign instr_ready = ready_q & ~flush;
  assign accept      = instr_valid & instr_ready;
  assign out_free    = ~dec_valid_q | dec_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      dec_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (flush) begin
      dec_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b1;
    end else if (out_free) begin
      // The skid entry is older than anything arriving now, so it goes first.
      // accept is necessarily 0 while the skid is occupied.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        dec_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else if (accept) begin
        out_q       <= dec;
        dec_valid_q <= 1'b1;
      end else begin
        dec_valid_q <= 1'b0;
      end
    end else if (accept) begin
      // Output stalled: park the new bundle and stop accepting.
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
      ready_q      <= 1'b0;
    end
  end
`else
  assign instr_ready = ~flush & (~dec_valid_q | dec_ready);
  assign accept      = instr_valid & instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      dec_valid_q <= 1'b0;
    end else if (flush) begin
      dec_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= dec;
      dec_valid_q <= 1'b1;
    end else if (dec_ready) begin
      dec_valid_q <= 1'b0;
    end
  end
`endif

  assign dec_valid = dec_valid_q;
  assign dec_pc    = out_q.pc;
  assign alu_op    = out_q.alu_op;
  assign src_a_sel = out_q.src_a_sel;
  assign src_b_sel = out_q.src_b_sel;
  assign imm       = out_q.imm;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign rd        = out_q.rd;
  assign reg_we    = out_q.reg_we;
  assign mem_req   = out_q.mem_req;
  assign mem_we    = out_q.mem_we;
  assign mem_size  = out_q.mem_size;
  assign branch    = out_q.branch;
  assign jal       = out_q.jal;
  assign jalr      = out_q.jalr;
  assign illegal   = out_q.illegal;

endmodule
